tty_out_iot: RTL and testbench
==============================

Name: tty_out_iot

Overview:
- KL8E-style teletype printer/punch controller; consumes IOT instructions from the CPU's IOT execution step.
- Decodes device code 04 (IOT 604x). Drives the CPU skip and flag lines.
- Loads AC[7:0] into a character buffer and serialises it as 8N1/8N2 async on TXD.
- Sits directly downstream of the CPU's IOT path, alongside SKIP/LINK on the IR/AC buses.

Parameters:
- CLKS_PER_BIT, 1250, SYSCLK cycles per serial bit (12 MHz / 9600); legal range 2..65535
- STOP_BITS, 1, number of stop bits, 1 or 2
- FORCE_MARK, 1, when 1, bit 7 of the transmitted byte is forced to 1 (ASR-33 mark parity)
- DEVCODE, 6'o04, IOT device code that this block answers

Ports:
- SYSCLK  in  1  system clock; the only clock
- CLEAR  in  1  synchronous, active-high reset; driven from sw_CLEAR
- IOT_STB  in  1  one-SYSCLK pulse while an IOT instruction is in execute step 1; qualified by instIOT
- IR  in  12  instruction register bus
- AC  in  12  accumulator output (accout1)
- SKIP  out  1  request to increment PC; combinational, valid only during IOT_STB
- FLAG  out  1  printer flag: ready for next character
- BUSY  out  1  shifter active
- OVERRUN  out  1  sticky; a load was issued while BUSY
- TXD  out  1  serial output, idles high

Behaviour:
- Reset (CLEAR=1 at a SYSCLK edge): FLAG=0, BUSY=0, OVERRUN=0, TXD=1, state IDLE, counters=0.
- CLEAR overrides a transfer in progress; the partial character is abandoned and TXD returns high on the next edge.
- Select: sel = IOT_STB & (IR[11:9]==3'o6) & (IR[8:3]==DEVCODE). Micro-op bits: IR[0]=skip-if-flag, IR[1]=clear flag, IR[2]=load-and-print.
  - 6040: no bits set; sets FLAG.
  - 6041 TSF, 6042 TCF, 6044 TPC, 6046 TLS: bit combinations as listed. 6045 = TSF+TPC; 6047 = all three.
- SKIP = sel & IR[0] & FLAG. This uses the FLAG value before any same-cycle update.
- Flag update on a sel edge:
  - if IR[1], FLAG<=0;
  - if IR[2:0]==0, FLAG<=1.
- Load (sel & IR[2]):
  - if !BUSY: shift register <= {FORCE_MARK ? 1 : AC[7], AC[6:0]}; BUSY<=1; state START; bit timer=0.
  - if BUSY: character dropped; OVERRUN<=1; the transfer in progress is unaffected.
- Shifter FSM:
  - IDLE -> START (on load).
  - START, TXD=0, lasts CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; bit index 0..7 -> STOP.
  - STOP, TXD=1, lasts STOP_BITS*CLKS_PER_BIT cycles -> IDLE.
  - TXD is registered. The first edge after the load edge drives the start bit.
- Completion: on the last STOP cycle, BUSY<=0 and FLAG<=1.
  - If a sel with IR[1] occurs on the same edge, the set wins; a completion is never lost.
- Character time = (1+8+STOP_BITS)*CLKS_PER_BIT cycles from the load edge to BUSY falling.
- A new load on the same edge as completion is treated as !BUSY; the next character starts with no idle gap.
- Bit timer width = clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT-1. The timer never free-runs in IDLE.
- An IOT with a non-matching device code, or IOT_STB=0, has no effect and SKIP=0.

Decomposition:
- Shared package pdp8_iot_pkg:
  - IOT opcode 3'o6;
  - device code constants (TTY_IN 6'o03, TTY_OUT 6'o04);
  - micro-op bit indices (IOP1=0, IOP2=1, IOP4=2);
  - FSM state enum {IDLE, START, DATA, STOP}.
- One sub-module, uart_tx_core: holds the shift register, bit timer, bit counter, FSM and TXD.
  - Interface: load/data in; busy/done out.
- tty_out_iot keeps the IOT decode, FLAG, SKIP and OVERRUN. uart_tx_core is reused by the future keyboard/reader block's echo path.

Test Plan:
- Reset: hold CLEAR for 2 cycles -> FLAG=0, BUSY=0, OVERRUN=0, TXD=1; IOT 6041 -> SKIP=0.
- TLS: CLKS_PER_BIT=4, STOP_BITS=1, FORCE_MARK=1, AC=12'o0101, IOT 6046.
  - TXD sequence 0,1,0,0,0,0,0,1,1,1, each level 4 cycles (byte 8'hC1).
  - BUSY falls and FLAG rises exactly 40 cycles after the load edge; 6041 then gives SKIP=1.
- Flag ops: 6040 -> FLAG=1; 6041 -> SKIP=1; 6042 -> FLAG=0; 6041 -> SKIP=0; an IOT 6031 (other device) -> no change.
- Overrun: IOT 6046 with AC=0o0125, then 6044 with AC=0o0177 after 10 cycles.
  - OVERRUN=1; the serialised byte is still 8'hD5; only one character appears on TXD.
- Collision: issue 6042 on the exact completion edge -> FLAG=1. Then CLEAR mid-DATA -> TXD=1, BUSY=0 on the next edge, and no flag set.
- STOP_BITS=2, FORCE_MARK=0, AC=0o0000: TXD low for 36 cycles, then high for 8 cycles; FLAG rises at cycle 44.

Source files
------------

// File: rtl/pdp8_iot_pkg.sv
// rtl/pdp8_iot_pkg.sv - shared PDP-8 IOT decode constants and serial shifter state type
package pdp8_iot_pkg;

    // Major opcode for IOT instructions (IR[11:9])
    localparam logic [2:0] IOT_OP = 3'o6;

    // Device codes (IR[8:3])
    localparam logic [5:0] DEV_TTY_IN  = 6'o03;
    localparam logic [5:0] DEV_TTY_OUT = 6'o04;

    // Micro-op bit positions within IR[2:0]
    localparam int IOP1 = 0;
    localparam int IOP2 = 1;
    localparam int IOP4 = 2;

    // Async serial shifter states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // True when an IOT strobe addresses the given device code
    function automatic logic iot_select(
        input logic        stb,
        input logic [11:0] ir,
        input logic [5:0]  dev
    );
        return stb && (ir[11:9] == IOT_OP) && (ir[8:3] == dev);
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8-bit async transmitter, 8N1/8N2, registered TXD
module uart_tx_core
    import pdp8_iot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       txd
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t         state;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              bit_end;

    assign bit_end = (timer == T_LAST);

    // Last cycle of the final stop bit; the owner sets its flag on this same edge
    assign done = (state == STOP) && bit_end && (bit_idx == STOP_LAST);

    // Shifter FSM: bit timer, bit/stop counter, shift register, busy and TXD
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            txd     <= 1'b1;
        end else begin
            // TXD lags the state by one edge, so the start bit appears one edge after load
            case (state)
                IDLE:    txd <= 1'b1;
                START:   txd <= 1'b0;
                DATA:    txd <= shreg[0];
                STOP:    txd <= 1'b1;
                default: txd <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (load) begin
                        shreg <= data;
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            // A load arriving with completion chains straight into the next start bit
                            if (load) begin
                                shreg <= data;
                                state <= START;
                                busy  <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tty_out_iot.sv
// rtl/tty_out_iot.sv - KL8E-style teletype printer IOT controller (device 04)
module tty_out_iot
    import pdp8_iot_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 1250,
    parameter int          STOP_BITS    = 1,
    parameter int          FORCE_MARK   = 1,
    parameter logic [5:0]  DEVCODE      = 6'o04
) (
    input  logic        SYSCLK,
    input  logic        CLEAR,
    input  logic        IOT_STB,
    input  logic [11:0] IR,
    input  logic [11:0] AC,
    output logic        SKIP,
    output logic        FLAG,
    output logic        BUSY,
    output logic        OVERRUN,
    output logic        TXD
);

    logic       sel;
    logic       load_req;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       unused_ac_hi;

    assign sel      = iot_select(IOT_STB, IR, DEVCODE);
    assign load_req = sel && IR[IOP4];

    // Skip tests the flag as it stood before this edge's update
    assign SKIP = sel && IR[IOP1] && FLAG;

    // Mark parity forces bit 7 high for ASR-33 style terminals
    assign tx_data = {((FORCE_MARK != 0) ? 1'b1 : AC[7]), AC[6:0]};

    // Only the low eight accumulator bits are ever printed
    assign unused_ac_hi = ^AC[11:8];

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) u_tx (
        .clk  (SYSCLK),
        .rst  (CLEAR),
        .load (load_req),
        .data (tx_data),
        .busy (BUSY),
        .done (tx_done),
        .txd  (TXD)
    );

    // Printer flag and sticky overrun; completion always beats a same-edge flag clear
    always_ff @(posedge SYSCLK) begin
        if (CLEAR) begin
            FLAG    <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            if (tx_done) begin
                FLAG <= 1'b1;
            end else if (sel && IR[IOP2]) begin
                FLAG <= 1'b0;
            end else if (sel && (IR[2:0] == 3'b000)) begin
                FLAG <= 1'b1;
            end

            if (load_req && BUSY && !tx_done) begin
                OVERRUN <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tty_out_iot.sv
// tb/tb_tty_out_iot.sv - directed self-checking bench for tty_out_iot
module tb_tty_out_iot;

    logic        SYSCLK;
    logic        CLEAR;
    logic        IOT_STB;
    logic [11:0] IR;
    logic [11:0] AC;
    logic        skip1, flag1, busy1, overrun1, txd1;
    logic        skip2, flag2, busy2, overrun2, txd2;

    int total = 0;
    int bad   = 0;

    tty_out_iot #(.CLKS_PER_BIT(4), .STOP_BITS(1), .FORCE_MARK(1), .DEVCODE(6'o04)) dut1 (
        .SYSCLK(SYSCLK), .CLEAR(CLEAR), .IOT_STB(IOT_STB), .IR(IR), .AC(AC),
        .SKIP(skip1), .FLAG(flag1), .BUSY(busy1), .OVERRUN(overrun1), .TXD(txd1)
    );

    tty_out_iot #(.CLKS_PER_BIT(4), .STOP_BITS(2), .FORCE_MARK(0), .DEVCODE(6'o04)) dut2 (
        .SYSCLK(SYSCLK), .CLEAR(CLEAR), .IOT_STB(IOT_STB), .IR(IR), .AC(AC),
        .SKIP(skip2), .FLAG(flag2), .BUSY(busy2), .OVERRUN(overrun2), .TXD(txd2)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic iot(input logic [11:0] ir, input logic [11:0] ac, output logic sk);
        @(negedge SYSCLK);
        IR = ir;
        AC = ac;
        IOT_STB = 1'b1;
        #1 sk = skip1;
        @(negedge SYSCLK);
        IOT_STB = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge SYSCLK);
        CLEAR = 1'b1;
        repeat (2) @(negedge SYSCLK);
        CLEAR = 1'b0;
    endtask

    task automatic test_reset();
        logic sk;
        CLEAR = 1'b1;
        repeat (2) @(negedge SYSCLK);
        total++; if (flag1 !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b want=0", flag1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
        total++; if (overrun1 !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun1); end
        total++; if (txd1 !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b want=1", txd1); end
        CLEAR = 1'b0;
        iot(12'o6041, 12'o0000, sk);
        total++; if (sk !== 1'b0) begin bad++; $display("FAIL reset_skip got=%b want=0", sk); end
    endtask

    task automatic test_tls();
        logic sk;
        logic [9:0] frame;
        frame = {1'b1, 8'hC1, 1'b0};
        do_clear();
        iot(12'o6046, 12'o0101, sk);
        total++; if (txd1 !== 1'b1) begin bad++; $display("FAIL tls_load_edge_txd got=%b want=1", txd1); end
        for (int k = 1; k <= 40; k++) begin
            @(negedge SYSCLK);
            total++;
            if (txd1 !== frame[(k-1)/4]) begin
                bad++; $display("FAIL tls_txd cyc=%0d got=%b want=%b", k, txd1, frame[(k-1)/4]);
            end
            if (k == 39) begin
                total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL tls_busy39 got=%b want=1", busy1); end
                total++; if (flag1 !== 1'b0) begin bad++; $display("FAIL tls_flag39 got=%b want=0", flag1); end
            end
        end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL tls_busy40 got=%b want=0", busy1); end
        total++; if (flag1 !== 1'b1) begin bad++; $display("FAIL tls_flag40 got=%b want=1", flag1); end
        iot(12'o6041, 12'o0000, sk);
        total++; if (sk !== 1'b1) begin bad++; $display("FAIL tls_skip got=%b want=1", sk); end
    endtask

    task automatic test_flag_ops();
        logic sk;
        iot(12'o6042, 12'o0000, sk);
        total++; if (flag1 !== 1'b0) begin bad++; $display("FAIL tcf_flag got=%b want=0", flag1); end
        iot(12'o6040, 12'o0000, sk);
        total++; if (flag1 !== 1'b1) begin bad++; $display("FAIL 6040_flag got=%b want=1", flag1); end
        iot(12'o6041, 12'o0000, sk);
        total++; if (sk !== 1'b1) begin bad++; $display("FAIL tsf_skip_set got=%b want=1", sk); end
        iot(12'o6032, 12'o0000, sk);
        total++; if (flag1 !== 1'b1) begin bad++; $display("FAIL otherdev_clear_flag got=%b want=1", flag1); end
        @(negedge SYSCLK);
        IR = 12'o6042;
        IOT_STB = 1'b0;
        @(negedge SYSCLK);
        total++; if (flag1 !== 1'b1) begin bad++; $display("FAIL nostb_flag got=%b want=1", flag1); end
        iot(12'o6042, 12'o0000, sk);
        total++; if (flag1 !== 1'b0) begin bad++; $display("FAIL tcf2_flag got=%b want=0", flag1); end
        iot(12'o6041, 12'o0000, sk);
        total++; if (sk !== 1'b0) begin bad++; $display("FAIL tsf_skip_clr got=%b want=0", sk); end
        iot(12'o6031, 12'o0000, sk);
        total++; if (sk !== 1'b0) begin bad++; $display("FAIL otherdev_skip got=%b want=0", sk); end
        total++; if (flag1 !== 1'b0) begin bad++; $display("FAIL otherdev_flag got=%b want=0", flag1); end
        iot(12'o6030, 12'o0000, sk);
        total++; if (flag1 !== 1'b0) begin bad++; $display("FAIL otherdev_set_flag got=%b want=0", flag1); end
    endtask

    task automatic test_overrun();
        logic sk;
        logic [9:0] frame;
        frame = {1'b1, 8'hD5, 1'b0};
        do_clear();
        iot(12'o6046, 12'o0125, sk);
        for (int k = 1; k <= 52; k++) begin
            @(negedge SYSCLK);
            total++;
            if (k <= 40) begin
                if (txd1 !== frame[(k-1)/4]) begin
                    bad++; $display("FAIL ovr_txd cyc=%0d got=%b want=%b", k, txd1, frame[(k-1)/4]);
                end
            end else begin
                if (txd1 !== 1'b1) begin bad++; $display("FAIL ovr_idle_txd cyc=%0d got=%b want=1", k, txd1); end
            end
            if (k == 9) begin
                IR = 12'o6044; AC = 12'o0177; IOT_STB = 1'b1;
            end
            if (k == 10) IOT_STB = 1'b0;
        end
        total++; if (overrun1 !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", overrun1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL ovr_busy got=%b want=0", busy1); end
        total++; if (flag1 !== 1'b1) begin bad++; $display("FAIL ovr_done_flag got=%b want=1", flag1); end
    endtask

    task automatic test_back_to_back();
        logic sk;
        logic [9:0] f1;
        logic [9:0] f2;
        logic       e;
        f1 = {1'b1, 8'hC1, 1'b0};
        f2 = {1'b1, 8'hAA, 1'b0};
        do_clear();
        iot(12'o6046, 12'o0101, sk);
        for (int k = 1; k <= 80; k++) begin
            @(negedge SYSCLK);
            e = (k <= 40) ? f1[(k-1)/4] : f2[(k-41)/4];
            total++;
            if (txd1 !== e) begin bad++; $display("FAIL b2b_txd cyc=%0d got=%b want=%b", k, txd1, e); end
            if (k == 39) begin
                IR = 12'o6046; AC = 12'o0052; IOT_STB = 1'b1;
            end
            if (k == 40) begin
                IOT_STB = 1'b0;
                total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy1); end
                total++; if (flag1 !== 1'b1) begin bad++; $display("FAIL b2b_flag got=%b want=1", flag1); end
                total++; if (overrun1 !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", overrun1); end
            end
        end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL b2b_end_busy got=%b want=0", busy1); end
    endtask

    task automatic test_collision();
        logic sk;
        do_clear();
        iot(12'o6046, 12'o0101, sk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge SYSCLK);
            if (k == 39) begin
                IR = 12'o6042; IOT_STB = 1'b1;
            end
        end
        IOT_STB = 1'b0;
        total++; if (flag1 !== 1'b1) begin bad++; $display("FAIL coll_flag got=%b want=1", flag1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL coll_busy got=%b want=0", busy1); end
        iot(12'o6046, 12'o0101, sk);
        repeat (15) @(negedge SYSCLK);
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL clr_pre_busy got=%b want=1", busy1); end
        CLEAR = 1'b1;
        @(negedge SYSCLK);
        CLEAR = 1'b0;
        total++; if (txd1 !== 1'b1) begin bad++; $display("FAIL clr_txd got=%b want=1", txd1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b want=0", busy1); end
        repeat (40) @(negedge SYSCLK);
        total++; if (flag1 !== 1'b0) begin bad++; $display("FAIL clr_flag got=%b want=0", flag1); end
        total++; if (txd1 !== 1'b1) begin bad++; $display("FAIL clr_idle_txd got=%b want=1", txd1); end
    endtask

    task automatic test_two_stop();
        logic sk;
        logic e;
        do_clear();
        iot(12'o6046, 12'o0000, sk);
        for (int k = 1; k <= 44; k++) begin
            @(negedge SYSCLK);
            e = (k <= 36) ? 1'b0 : 1'b1;
            total++;
            if (txd2 !== e) begin bad++; $display("FAIL stop2_txd cyc=%0d got=%b want=%b", k, txd2, e); end
            if (k == 43) begin
                total++; if (flag2 !== 1'b0) begin bad++; $display("FAIL stop2_flag43 got=%b want=0", flag2); end
                total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL stop2_busy43 got=%b want=1", busy2); end
            end
        end
        total++; if (flag2 !== 1'b1) begin bad++; $display("FAIL stop2_flag44 got=%b want=1", flag2); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL stop2_busy44 got=%b want=0", busy2); end
    endtask

    initial begin
        CLEAR   = 1'b1;
        IOT_STB = 1'b0;
        IR      = 12'o0000;
        AC      = 12'o0000;
        test_reset();
        test_tls();
        test_flag_ops();
        test_overrun();
        test_back_to_back();
        test_collision();
        test_two_stop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
